// File: rtl/uart_rx.sv
// uart_rx: oversampling serial receiver for 8N1/8E1/8O1 frames.
// RX_IN is sampled three times around mid-bit and resolved by 2-of-3 vote;
// parity/stop errors are flagged and Data_valid pulses for each clean frame.
module uart_rx #(
    parameter int Out_Data_Width = 8,
    parameter int Prescale_Width = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [Prescale_Width-1:0] Prescale,
    output logic [Out_Data_Width-1:0] P_DATA,
    output logic                      Data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BCW = (Out_Data_Width > 1) ? $clog2(Out_Data_Width) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [Prescale_Width-1:0] P_ONE    = Prescale_Width'(1);
    localparam logic [BCW-1:0]            B_ONE    = BCW'(1);
    localparam logic [BCW-1:0]            B_LAST   = BCW'(Out_Data_Width - 1);

    logic [2:0]                state_q, state_d;
    logic [Prescale_Width-1:0] edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [1:0]                samp_q, samp_d;
    logic                      bit_val_q, bit_val_d;
    logic [Out_Data_Width-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic [1:0]                err_q, err_d;
    logic [1:0]                error_flag_word_UART_Rx;

    logic [Prescale_Width-1:0] half;
    logic                      last_edge, at_s0, at_s1, at_s2, maj;

    assign half      = Prescale >> 1;
    assign last_edge = (edge_cnt_q == Prescale - P_ONE);
    assign at_s0     = (edge_cnt_q == half - P_ONE);
    assign at_s1     = (edge_cnt_q == half);
    assign at_s2     = (edge_cnt_q == half + P_ONE);
    assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & RX_IN) | (samp_q[1] & RX_IN);

    assign error_flag_word_UART_Rx = err_q;
    assign par_err    = error_flag_word_UART_Rx[1];
    assign stp_err    = error_flag_word_UART_Rx[0];
    assign P_DATA     = data_q;
    assign Data_valid = valid_q;

    // Next-state logic: bit timing, majority sampling, shifting and error flags.
    // The cycle in which IDLE sees the falling edge is counted as edge 0 of the
    // start bit, so the counter enters START at 1 and stays aligned to the line;
    // this keeps all three samples inside the bit even at Prescale = 4.
    // Decisions taken at the last edge use the _d flag/vote values so that the
    // third sample and the end of bit may coincide (Prescale = 4).
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        bit_val_d  = bit_val_q;
        data_d     = data_q;
        err_d      = err_q;
        valid_d    = 1'b0;

        if (state_q == IDLE) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
            if (!RX_IN) begin
                state_d    = START;
                edge_cnt_d = P_ONE;
                err_d      = '0;
            end
        end else begin
            edge_cnt_d = last_edge ? '0 : edge_cnt_q + P_ONE;
            if (at_s0) samp_d[0] = RX_IN;
            if (at_s1) samp_d[1] = RX_IN;
            if (at_s2) bit_val_d = maj;

            case (state_q)
                START: begin
                    if (last_edge) state_d = bit_val_d ? IDLE : DATA;
                end
                DATA: begin
                    if (at_s2) data_d = {maj, data_q[Out_Data_Width-1:1]};
                    if (last_edge) begin
                        if (bit_cnt_q == B_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = PAR_EN ? PARITY : STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + B_ONE;
                        end
                    end
                end
                PARITY: begin
                    if (at_s2) err_d[1] = maj ^ (^data_q) ^ PAR_TYP;
                    if (last_edge) state_d = err_d[1] ? IDLE : STOP;
                end
                STOP: begin
                    if (at_s2) err_d[0] = ~maj;
                    if (last_edge) begin
                        valid_d = ~err_d[1] & ~err_d[0];
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            bit_val_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            bit_val_q  <= bit_val_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level reference model for uart_rx with randomized frames.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       Data_valid;
    logic       par_err;
    logic       stp_err;

    int unsigned n_checks   = 0;
    int unsigned n_fail     = 0;
    int unsigned pulses     = 0;
    int unsigned exp_pulses = 0;
    logic [7:0]  exp_data   = 8'h00;

    always #5 CLK = ~CLK;

    uart_rx #(.Out_Data_Width(8), .Prescale_Width(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    // Count every cycle Data_valid is high; a stretched pulse counts twice.
    always @(negedge CLK) if (RST && Data_valid) pulses <= pulses + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic dv, input logic pe,
                                 input logic se, input logic [7:0] d);
        check({tag, ".valid"}, 32'(Data_valid), 32'(dv));
        check({tag, ".par"},   32'(par_err),    32'(pe));
        check({tag, ".stp"},   32'(stp_err),    32'(se));
        check({tag, ".data"},  32'(P_DATA),     32'(d));
    endtask

    // Hold the line at b for n clock cycles; entered and left at a negedge.
    task automatic line(input logic b, input int unsigned n);
        RX_IN = b;
        repeat (n) @(negedge CLK);
    endtask

    // One bit period; optional 1-cycle inversion on the middle sample point.
    task automatic send_bit(input logic b, input logic glitch);
        if (glitch) begin
            line(b, Prescale / 2);
            line(~b, 1);
            line(b, Prescale / 2 - 1);
        end else begin
            line(b, Prescale);
        end
    endtask

    // Drive one frame and check the outputs at the end of its last line bit.
    // A parity failure abandons the frame, so no stop bit is sent then.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic pen,
                              input logic ptyp, input logic par_ok, input logic stop_b,
                              input logic glitch);
        logic pbit;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch && (i == 3 || i == 6));
        exp_data = d;
        if (pen) begin
            // even: parity bit makes total ones even; odd: makes it odd
            pbit = (^d) ^ ptyp;
            if (!par_ok) pbit = ~pbit;
            send_bit(pbit, 1'b0);
        end
        if (pen && !par_ok) begin
            check_outputs(tag, 1'b0, 1'b1, 1'b0, d);
        end else begin
            send_bit(stop_b, 1'b0);
            if (stop_b) exp_pulses++;
            check_outputs(tag, stop_b, 1'b0, ~stop_b, d);
        end
    endtask

    // Single-cycle low spike in idle: a false start that must be rejected.
    task automatic spike(input string tag);
        line(1'b1, 1);
        line(1'b0, 1);
        line(1'b1, Prescale + 2);
        check_outputs(tag, 1'b0, 1'b0, 1'b0, exp_data);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] ptab [4];
        ptab[0] = 6'd4; ptab[1] = 6'd8; ptab[2] = 6'd16; ptab[3] = 6'd32;

        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
        repeat (3) @(negedge CLK);
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 8'h00);
        RST = 1'b1;
        line(1'b1, 4);

        // Directed cases at Prescale = 8
        send_frame("t1",  8'b10011001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        line(1'b1, 3);
        send_frame("t2",  8'b10011001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        line(1'b1, 3);
        send_frame("t3a", 8'b10011001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame("t3b", 8'b01010101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        line(1'b1, 3);
        send_frame("t4a", 8'b10011001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame("t4b", 8'b01010101, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        line(1'b1, 3);
        send_frame("t5a", 8'hA7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame("t5b", 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        line(1'b1, 3);
        send_frame("t6a", 8'h5E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        line(1'b1, 2);
        send_frame("t6b", 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        spike("t6g");

        // Reset in the middle of a frame clears everything immediately
        PAR_EN = 1'b0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        RST = 1'b0; RX_IN = 1'b1;
        #1;
        exp_data = 8'h00;
        check_outputs("midrst", 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge CLK);
        RST = 1'b1;
        line(1'b1, 3);

        // Randomized frames over all legal prescales
        for (int n = 0; n < 40; n++) begin
            string tag;
            tag = $sformatf("rnd%0d", n);
            Prescale = ptab[$urandom_range(0, 3)];
            line(1'b1, 2);
            if ($urandom_range(0, 7) == 0) spike({tag, ".spk"});
            send_frame(tag, 8'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                       1'($urandom));
            if ($urandom_range(0, 1) == 1) line(1'b1, $urandom_range(1, 6));
        end

        line(1'b1, 4);
        check("pulses", pulses, exp_pulses);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
